// File: rtl/wham_display_core.sv
// Whac-A-Mole 7-segment front end: difficulty digit, clamped score with leading-zero blanking,
// and a millisecond reaction timer. All segment outputs are active-low (common anode).
module wham_display_core #(
   parameter int unsigned CLKS_PER_MS = 50000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_evt,
   input  logic        stop_evt,
   input  logic [15:0] score,
   input  logic [2:0]  diff,
   output logic [6:0]  hex0,
   output logic [6:0]  hex1,
   output logic [6:0]  hex2,
   output logic [6:0]  hex3,
   output logic [6:0]  hex4,
   output logic [6:0]  hex5,
   output logic [6:0]  hex6
);

   localparam int unsigned PW = (CLKS_PER_MS > 2) ? $clog2(CLKS_PER_MS) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(CLKS_PER_MS - 1);
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] MS_MAX    = 7'd99;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // Difficulty: purely combinational, anything not strictly one-hot shows a dash
   always_comb begin
      hex4 = SEG_DASH;
      case (diff)
         3'b001:  hex4 = seg7(4'd1);
         3'b010:  hex4 = seg7(4'd2);
         3'b100:  hex4 = seg7(4'd3);
         default: hex4 = SEG_DASH;
      endcase
   end

   // Score: clamp to 9999, then shift-add-3 binary to BCD
   logic [13:0] score_sat;
   logic [29:0] dd;
   logic [15:0] bcd;
   logic [6:0]  hex0_d, hex1_d, hex2_d, hex3_d;
   logic [6:0]  hex0_q, hex1_q, hex2_q, hex3_q;

   assign score_sat = (score > 16'd9999) ? 14'd9999 : score[13:0];

   always_comb begin
      dd = {16'd0, score_sat};
      for (int i = 0; i < 14; i++) begin
         for (int j = 0; j < 4; j++) begin
            if (dd[14+4*j +: 4] >= 4'd5) begin
               dd[14+4*j +: 4] = dd[14+4*j +: 4] + 4'd3;
            end
         end
         dd = dd << 1;
      end
      bcd = dd[29:14];
   end

   always_comb begin
      hex0_d = seg7(bcd[3:0]);
      hex1_d = (bcd[15:4] == 12'd0) ? SEG_BLANK : seg7(bcd[7:4]);
      hex2_d = (bcd[15:8] == 8'd0) ? SEG_BLANK : seg7(bcd[11:8]);
      hex3_d = (bcd[15:12] == 4'd0) ? SEG_BLANK : seg7(bcd[15:12]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hex0_q <= seg7(4'd0);
         hex1_q <= SEG_BLANK;
         hex2_q <= SEG_BLANK;
         hex3_q <= SEG_BLANK;
      end else begin
         hex0_q <= hex0_d;
         hex1_q <= hex1_d;
         hex2_q <= hex2_d;
         hex3_q <= hex3_d;
      end
   end

   assign hex0 = hex0_q;
   assign hex1 = hex1_q;
   assign hex2 = hex2_q;
   assign hex3 = hex3_q;

   // Reaction timer; start has priority over stop so a coincident pair restarts
   logic          running_q, running_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [6:0]    ms_q, ms_d;
   logic [6:0]    hex5_q, hex6_q;
   logic [3:0]    ms_tens, ms_ones;

   always_comb begin
      running_d = running_q;
      presc_d   = presc_q;
      ms_d      = ms_q;
      if (start_evt) begin
         running_d = 1'b1;
         presc_d   = '0;
         ms_d      = '0;
      end else if (running_q && stop_evt) begin
         running_d = 1'b0;
      end else if (running_q) begin
         if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            if (ms_q < MS_MAX) begin
               ms_d = ms_q + 7'd1;
            end
         end else begin
            presc_d = presc_q + PW'(1);
         end
      end
   end

   // Display registers load from ms_d so digits change on the same edge as the count
   always_comb begin
      ms_tens = 4'd0;
      for (int t = 1; t <= 9; t++) begin
         if (ms_d >= 7'(10 * t)) begin
            ms_tens = 4'(t);
         end
      end
      ms_ones = 4'(ms_d - 7'(10 * ms_tens));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         running_q <= 1'b0;
         presc_q   <= '0;
         ms_q      <= '0;
         hex5_q    <= seg7(4'd0);
         hex6_q    <= SEG_BLANK;
      end else begin
         running_q <= running_d;
         presc_q   <= presc_d;
         ms_q      <= ms_d;
         hex5_q    <= seg7(ms_ones);
         hex6_q    <= (ms_tens == 4'd0) ? SEG_BLANK : seg7(ms_tens);
      end
   end

   assign hex5 = hex5_q;
   assign hex6 = hex6_q;

endmodule

// File: tb/tb_wham_display_core.sv
// Randomized and directed bench for wham_display_core against a tick-counting reference model.
module tb_wham_display_core;

   localparam int unsigned CPM = 5;
   localparam logic [6:0] BLANK = 7'b1111111;
   localparam logic [6:0] DASH  = 7'b0111111;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_evt, stop_evt;
   logic [15:0] score;
   logic [2:0]  diff;
   logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6;

   int total = 0;
   int bad   = 0;

   logic [6:0] segtab [10];

   // Reference model state
   bit m_run;
   int m_ticks;
   int m_disp;

   wham_display_core #(.CLKS_PER_MS(CPM)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start_evt (start_evt),
      .stop_evt  (stop_evt),
      .score     (score),
      .diff      (diff),
      .hex0      (hex0),
      .hex1      (hex1),
      .hex2      (hex2),
      .hex3      (hex3),
      .hex4      (hex4),
      .hex5      (hex5),
      .hex6      (hex6)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%b exp=%b", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_run   = 1'b0;
      m_ticks = 0;
      m_disp  = 0;
   endtask

   task automatic check_all(input string tag);
      int sv, ms;
      logic [6:0] e4;
      sv = m_disp;
      ms = m_ticks / CPM;
      if (ms > 99) ms = 99;
      case (diff)
         3'b001:  e4 = segtab[1];
         3'b010:  e4 = segtab[2];
         3'b100:  e4 = segtab[3];
         default: e4 = DASH;
      endcase
      check({tag, ".hex0"}, 32'(hex0), 32'(segtab[sv % 10]));
      check({tag, ".hex1"}, 32'(hex1), 32'((sv >= 10) ? segtab[(sv / 10) % 10] : BLANK));
      check({tag, ".hex2"}, 32'(hex2), 32'((sv >= 100) ? segtab[(sv / 100) % 10] : BLANK));
      check({tag, ".hex3"}, 32'(hex3), 32'((sv >= 1000) ? segtab[sv / 1000] : BLANK));
      check({tag, ".hex4"}, 32'(hex4), 32'(e4));
      check({tag, ".hex5"}, 32'(hex5), 32'(segtab[ms % 10]));
      check({tag, ".hex6"}, 32'(hex6), 32'((ms >= 10) ? segtab[ms / 10] : BLANK));
   endtask

   // Called at a negedge; applies events for one posedge and advances the model
   task automatic step(input bit st, input bit sp);
      start_evt = st;
      stop_evt  = sp;
      @(posedge clk);
      if (rst_n) begin
         m_disp = (score > 16'd9999) ? 9999 : int'(score);
         if (st) begin
            m_run   = 1'b1;
            m_ticks = 0;
         end else if (m_run && sp) begin
            m_run = 1'b0;
         end else if (m_run) begin
            m_ticks++;
         end
      end
      @(negedge clk);
      start_evt = 1'b0;
      stop_evt  = 1'b0;
   endtask

   initial begin
      int scores [6];
      logic [2:0] diffs [5];
      segtab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
      scores = '{0, 7, 12, 123, 9999, 10050};
      diffs  = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b011};

      rst_n = 1'b0;
      start_evt = 1'b0;
      stop_evt = 1'b0;
      score = 16'd4321;
      diff = 3'b001;
      model_reset();
      repeat (5) @(posedge clk);
      @(negedge clk);
      check_all("reset");
      rst_n = 1'b1;
      step(0, 0);
      score = 16'd0;
      step(0, 0);
      check_all("post_reset");

      foreach (diffs[i]) begin
         diff = diffs[i];
         #1;
         check_all($sformatf("diff%0d", i));
         @(negedge clk);
      end
      diff = 3'b010;

      foreach (scores[i]) begin
         score = 16'(scores[i]);
         repeat (8) step(0, 0);
         check_all($sformatf("score%0d", scores[i]));
      end

      step(1, 0);
      repeat (185) step(0, 0);
      step(0, 1);
      check_all("rt37");
      for (int i = 0; i < 12; i++) begin
         step(0, 0);
         check_all("rt37_hold");
      end
      step(0, 1);
      check_all("rt37_stop_idle");

      step(1, 0);
      repeat (40) step(0, 0);
      step(0, 1);
      check_all("rt8");

      step(1, 0);
      repeat (600) step(0, 0);
      check_all("rt_sat");
      step(1, 1);
      repeat (7) step(0, 0);
      check_all("rt_start_wins");

      // Asynchronous reset mid-measurement, checked before any further clock edge
      repeat (60) step(0, 0);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      @(negedge clk);
      check_all("async_rst_hold");
      rst_n = 1'b1;
      step(0, 1);
      check_all("stop_no_start");

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 7) == 0) score = 16'($urandom_range(0, 65535));
         else if ($urandom_range(0, 3) == 0) score = 16'($urandom_range(0, 1200));
         diff = 3'($urandom_range(0, 7));
         step($urandom_range(0, 59) == 0, $urandom_range(0, 29) == 0);
         check_all($sformatf("rand%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
